// File: rtl/nn_pkg.sv
// Shared constants and types for the pixel front-end and the neuron array.
//   PIX_OUT_W : packed slot width (one neuron pixel lane)
//   N_PIX     : real pixels per image
//   N_SLOT    : packed slots; the top N_SLOT-N_PIX slots are zero padding
//   FRAME_W   : width of the packed frame bus seen by every neuron unit
package nn_pkg;

  localparam int unsigned PIX_OUT_W = 10;
  localparam int unsigned N_PIX     = 784;
  localparam int unsigned N_SLOT    = 786;
  localparam int unsigned FRAME_W   = N_SLOT * PIX_OUT_W;  // 7860

  typedef enum logic [1:0] {
    StFill,
    StNnRst,
    StIssue,
    StWait
  } loader_state_e;

endpackage

// File: rtl/pixel_frame_loader_if.sv
// Serial pixel stream with a valid/ready handshake.
//   pix_valid : source has a pixel
//   pix_ready : sink accepts a pixel this cycle
//   pix_data  : unsigned pixel value
//   pix_last  : final pixel of an image
// Modports: master = pixel source, slave = loader.
interface pixel_frame_loader_if #(
  parameter int unsigned PIX_IN_W = 8
) ();

  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_IN_W-1:0] pix_data;
  logic                pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );

endinterface

// File: rtl/pix_convert.sv
// Combinational conversion of one input pixel into a packed frame slot.
//   pix_i  : input pixel, unsigned
//   slot_o : slot value
// Build option LOADER_BINARIZE_EN: slot is 255 when pix_i >= BIN_THRESH, else 0.
// Without it the pixel is zero-extended and BIN_THRESH has no effect.
module pix_convert #(
  parameter int unsigned PIX_IN_W   = 8,
  parameter int unsigned PIX_OUT_W  = 10,
  parameter int unsigned BIN_THRESH = 128
) (
  input  logic [PIX_IN_W-1:0]  pix_i,
  output logic [PIX_OUT_W-1:0] slot_o
);

`ifdef LOADER_BINARIZE_EN
  assign slot_o = (32'(pix_i) >= BIN_THRESH) ? PIX_OUT_W'(255) : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^BIN_THRESH;
  assign slot_o        = PIX_OUT_W'(pix_i);
`endif

endmodule

// File: rtl/pixel_frame_loader.sv
// Packs a serial pixel stream into the neuron array's frame bus, resets the
// array, issues the frame and holds it until the array reports a result.
//   clk, rst     : clock, synchronous active-high reset
//   pix_if       : pixel stream (slave side)
//   nn_rst       : one-cycle reset pulse to the neuron units
//   Input_Valid  : one-cycle frame-issue strobe
//   pixel        : packed frame, slot k at [PIX_OUT_W*k +: PIX_OUT_W]
//   Output_Valid : AND of all neuron Output_Valids (level)
//   frame_done   : one-cycle pulse when the array result is taken
//   frame_err    : one-cycle pulse on a pix_last framing mismatch
// Build option LOADER_BINARIZE_EN selects binarized slots (see pix_convert).
module pixel_frame_loader
  import nn_pkg::*;
#(
  parameter int unsigned PIX_IN_W   = 8,
  parameter int unsigned PIX_OUT_W  = nn_pkg::PIX_OUT_W,
  parameter int unsigned N_PIX      = nn_pkg::N_PIX,
  parameter int unsigned N_SLOT     = nn_pkg::N_SLOT,
  parameter int unsigned BIN_THRESH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  pixel_frame_loader_if.slave         pix_if,
  output logic                        nn_rst,
  output logic                        Input_Valid,
  output logic [N_SLOT*PIX_OUT_W-1:0] pixel,
  input  logic                        Output_Valid,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam int unsigned CntW      = 10;
  localparam int unsigned FrameRegW = N_PIX * PIX_OUT_W;
  localparam int unsigned IdxW      = $clog2(FrameRegW);
  localparam logic [CntW-1:0] LastIdx = CntW'(N_PIX - 1);

  loader_state_e          state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   wait_armed_q, wait_armed_d;
  logic [FrameRegW-1:0]   frame_q;
  logic                   wr_en;
  logic [PIX_OUT_W-1:0]   slot_val;
  logic [IdxW-1:0]        slot_base;

  pix_convert #(
    .PIX_IN_W  (PIX_IN_W),
    .PIX_OUT_W (PIX_OUT_W),
    .BIN_THRESH(BIN_THRESH)
  ) u_pix_convert (
    .pix_i (pix_if.pix_data),
    .slot_o(slot_val)
  );

  assign slot_base = IdxW'(32'(count_q) * PIX_OUT_W);

  // Pad slots are never stored; they are constant zero on the bus.
  assign pixel = {{((N_SLOT - N_PIX) * PIX_OUT_W){1'b0}}, frame_q};

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    wait_armed_d     = 1'b0;
    wr_en            = 1'b0;
    pix_if.pix_ready = 1'b0;
    nn_rst           = 1'b0;
    Input_Valid      = 1'b0;
    frame_done       = 1'b0;
    frame_err        = 1'b0;

    unique case (state_q)
      StFill: begin
        pix_if.pix_ready = 1'b1;
        if (pix_if.pix_valid) begin
          if (count_q == LastIdx) begin
            // The 784th pixel always closes the frame, last flag or not.
            wr_en     = 1'b1;
            count_d   = '0;
            state_d   = StNnRst;
            frame_err = ~pix_if.pix_last;
          end else if (pix_if.pix_last) begin
            // Early last: drop the pixel and restart; stale slots get overwritten.
            count_d   = '0;
            frame_err = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      StNnRst: begin
        nn_rst  = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        Input_Valid = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        // First WAIT cycle may see Output_Valid left over from the previous image.
        wait_armed_d = 1'b1;
        if (wait_armed_q && Output_Valid) begin
          frame_done = 1'b1;
          state_d    = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    if (rst) begin
      frame_done = 1'b0;
      frame_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      count_q      <= '0;
      wait_armed_q <= 1'b0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wait_armed_q <= wait_armed_d;
      if (wr_en) begin
        frame_q[slot_base +: PIX_OUT_W] <= slot_val;
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Self-checking bench for pixel_frame_loader: randomized pixel streams, a
// behavioural frame model, and an event scoreboard checked by a monitor.
module tb_pixel_frame_loader;
  import nn_pkg::*;

  localparam int unsigned FW = nn_pkg::FRAME_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nn_rst, Input_Valid, Output_Valid, frame_done, frame_err;
  logic [FW-1:0] pixel;

  always #5 clk = ~clk;

  pixel_frame_loader_if #(.PIX_IN_W(8)) pif ();

  pixel_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .pix_if      (pif),
    .nn_rst      (nn_rst),
    .Input_Valid (Input_Valid),
    .pixel       (pixel),
    .Output_Valid(Output_Valid),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef enum int {EvErr, EvNnRst, EvIssue, EvDone} ev_e;
  typedef struct {
    ev_e           kind;
    int            cyc;
    logic [FW-1:0] frame;
  } exp_t;

  exp_t          q[$];
  logic [FW-1:0] issued_frame = '0;
  int            ready_chk_cyc = -1;
  bit            mon_en = 1'b0;

  // Reference image: what the next issued frame should hold, pixel by pixel.
  int img[N_PIX];
  int pos    = 0;
  int last_t = 0;

  task automatic chk_val(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_frame(input string name, input logic [FW-1:0] act,
                           input logic [FW-1:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      int bad = 0;
      for (int k = N_SLOT - 1; k >= 0; k--)
        if (act[k*PIX_OUT_W +: PIX_OUT_W] != exp[k*PIX_OUT_W +: PIX_OUT_W]) bad = k;
      $display("FAIL %s: slot %0d got %0d, expected %0d (cycle %0d)", name, bad,
               act[bad*PIX_OUT_W +: PIX_OUT_W], exp[bad*PIX_OUT_W +: PIX_OUT_W], cyc);
    end
  endtask

  function automatic logic [9:0] conv(input int d);
`ifdef LOADER_BINARIZE_EN
    return (d >= 128) ? 10'd255 : 10'd0;
`else
    return 10'(d);
`endif
  endfunction

  task automatic push_ev(input ev_e k, input int c, input logic [FW-1:0] f);
    exp_t e;
    e.kind  = k;
    e.cyc   = c;
    e.frame = f;
    q.push_back(e);
  endtask

  // Expected consequences of one accepted pixel at cycle t.
  task automatic model_accept(input int d, input bit last, input int t);
    logic [FW-1:0] f;
    if (pos == N_PIX - 1) begin
      img[pos] = d;
      if (!last) push_ev(EvErr, t, '0);
      f = '0;
      for (int k = 0; k < N_PIX; k++) f[k*PIX_OUT_W +: PIX_OUT_W] = conv(img[k]);
      push_ev(EvNnRst, t + 1, '0);
      push_ev(EvIssue, t + 2, f);
      pos    = 0;
      last_t = t;
    end else if (last) begin
      push_ev(EvErr, t, '0);
      pos = 0;
    end else begin
      img[pos] = d;
      pos++;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tasks below start and end at 1 time unit after a rising edge.
  task automatic push_pixel(input int d, input bit last, input int gap);
    int guard = 0;
    pif.pix_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    while (!pif.pix_ready && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) chk_val("pix_ready wait", pif.pix_ready, 1);
    pif.pix_valid = 1'b1;
    pif.pix_data  = 8'(d);
    pif.pix_last  = last;
    model_accept(d, last, cyc);
    @(posedge clk);
    #1;
    pif.pix_valid = 1'b0;
    pif.pix_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit rnd, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int d;
      d = rnd ? int'($urandom_range(0, 255)) : (i % 256);
      push_pixel(d, i == last_at, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // d < 0: Output_Valid raised before issue; else raised d cycles into WAIT.
  task automatic finish_frame(input int t, input int d);
    int done_c;
    if (d < 0) begin
      Output_Valid = 1'b1;
      done_c       = t + 4;
    end else begin
      done_c = (d == 0) ? t + 4 : t + 3 + d;
    end
    push_ev(EvDone, done_c, '0);
    if (d >= 0) begin
      wait_until(t + 3 + d);
      Output_Valid = 1'b1;
    end
    wait_until(done_c + 1);
    Output_Valid = 1'b0;
  endtask

  task automatic pop_check(input ev_e k);
    if (q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected %s: got pulse at cycle %0d, expected none", k.name(), cyc);
    end else begin
      exp_t e;
      e = q.pop_front();
      chk_val({"event kind ", k.name()}, int'(k), int'(e.kind));
      chk_val({k.name(), " cycle"}, cyc, e.cyc);
      if (k == EvIssue && e.kind == EvIssue) begin
        chk_frame("issued frame", pixel, e.frame);
        issued_frame = e.frame;
      end
      if (k == EvDone) begin
        chk_frame("frame held at done", pixel, issued_frame);
        chk_val("pix_ready at done", pif.pix_ready, 0);
        ready_chk_cyc = cyc + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == ready_chk_cyc) chk_val("pix_ready after done", pif.pix_ready, 1);
      if (frame_err) pop_check(EvErr);
      if (nn_rst) pop_check(EvNnRst);
      if (Input_Valid) pop_check(EvIssue);
      if (frame_done) pop_check(EvDone);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int k = 0; k < N_PIX; k++) img[k] = 0;
    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    pif.pix_last  = 1'b0;
    Output_Valid  = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk_val("reset pix_ready", pif.pix_ready, 1);
    chk_val("reset nn_rst", nn_rst, 0);
    chk_val("reset Input_Valid", Input_Valid, 0);
    chk_val("reset frame_done", frame_done, 0);
    chk_val("reset frame_err", frame_err, 0);
    chk_frame("reset pixel", pixel, '0);
    mon_en = 1'b1;

    // Normal frame, pixel k = k mod 256, Output_Valid high before issue.
    send_frame(N_PIX, N_PIX - 1, 1'b0, 0);
    t = last_t;
    chk_val("pix_ready low after close", pif.pix_ready, 0);
    chk_val("slot 5", pixel[5*PIX_OUT_W +: PIX_OUT_W], conv(5));
    chk_val("slot 783", pixel[783*PIX_OUT_W +: PIX_OUT_W], conv(15));
    chk_val("slot 784", pixel[784*PIX_OUT_W +: PIX_OUT_W], 0);
    chk_val("slot 785", pixel[785*PIX_OUT_W +: PIX_OUT_W], 0);
    finish_frame(t, -1);

    // Random data with idle gaps.
    send_frame(N_PIX, N_PIX - 1, 1'b1, 3);
    finish_frame(last_t, int'($urandom_range(0, 4)));

    // Early last on pixel 100, then a normal frame.
    send_frame(100, 99, 1'b1, 1);
    chk_val("pix_ready after early last", pif.pix_ready, 1);
    send_frame(N_PIX, N_PIX - 1, 1'b1, 0);
    finish_frame(last_t, 2);

    // Missing last: error and issue both.
    send_frame(N_PIX, -1, 1'b1, 1);
    finish_frame(last_t, -1);

    // Reset during WAIT with Output_Valid high, then a following frame.
    send_frame(N_PIX, N_PIX - 1, 1'b1, 0);
    t = last_t;
    wait_until(t + 4);
    rst          = 1'b1;
    Output_Valid = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    Output_Valid = 1'b0;
    chk_val("pix_ready after rst", pif.pix_ready, 1);
    chk_frame("pixel after rst", pixel, '0);
    send_frame(N_PIX, N_PIX - 1, 1'b1, 2);
    finish_frame(last_t, 3);

    repeat (5) @(posedge clk);
    #1;
    chk_val("pending expectations", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
